// File: rtl/knight_fade.sv
// rtl/knight_fade.sv - PWM afterglow output stage for the knight LED sequencer
module knight_fade #(
    parameter int PWM_BITS  = 3,
    parameter int DECAY_DIV = 4
) (
    input  logic       ck,
    input  logic       res,
    input  logic [7:0] pat,
    input  logic       pat_vld,
    output logic [7:0] led,
    output logic       glow
);

    localparam int FW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

    localparam logic [PWM_BITS-1:0] LVL_MAX   = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] LVL_ONE   = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] LVL_ZERO  = '0;
    localparam logic [FW-1:0]       FCNT_LAST = FW'(DECAY_DIV - 1);
    localparam logic [FW-1:0]       FCNT_ONE  = FW'(1);

    logic [PWM_BITS-1:0] pcnt_q, pcnt_d;
    logic [FW-1:0]       fcnt_q, fcnt_d;
    logic                fend;
    logic                dstep;
    logic [PWM_BITS-1:0] lvl_q [8];
    logic [PWM_BITS-1:0] lvl_d [8];
    logic [7:0]          led_q, led_d;
    logic [7:0]          lvl_nz;

    // PWM phase counter and frame counter; dstep fires once per decay period
    always_comb begin
        fend   = (pcnt_q == LVL_MAX);
        dstep  = fend && (fcnt_q == FCNT_LAST);
        pcnt_d = pcnt_q + LVL_ONE;
        fcnt_d = fcnt_q;
        if (fend) begin
            fcnt_d = (fcnt_q == FCNT_LAST) ? '0 : fcnt_q + FCNT_ONE;
        end
    end

    // Per-LED level: a request snaps to full, otherwise decay saturating at zero
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            lvl_d[i] = lvl_q[i];
            if (pat_vld && pat[i]) begin
                lvl_d[i] = LVL_MAX;
            end else if (dstep && (lvl_q[i] != LVL_ZERO)) begin
                lvl_d[i] = lvl_q[i] - LVL_ONE;
            end
            // Compare against the current level so a fresh load shows one edge later
            led_d[i]  = (pcnt_q < lvl_q[i]);
            lvl_nz[i] = (lvl_q[i] != LVL_ZERO);
        end
    end

    // State registers; reset clears everything immediately, including led
    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            pcnt_q <= '0;
            fcnt_q <= '0;
            led_q  <= '0;
            for (int i = 0; i < 8; i++) begin
                lvl_q[i] <= '0;
            end
        end else begin
            pcnt_q <= pcnt_d;
            fcnt_q <= fcnt_d;
            led_q  <= led_d;
            for (int i = 0; i < 8; i++) begin
                lvl_q[i] <= lvl_d[i];
            end
        end
    end

    assign led  = led_q;
    assign glow = |lvl_nz;

endmodule

// File: tb/tb_knight_fade.sv
// tb/tb_knight_fade.sv - self-checking bench for knight_fade
module tb_knight_fade;

    localparam int PB   = 3;
    localparam int DD   = 4;
    localparam int MAXV = (1 << PB) - 1;
    localparam int FR   = 1 << PB;
    localparam int PER  = FR * DD;

    logic       ck = 1'b0;
    logic       res = 1'b0;
    logic [7:0] pat = 8'h00;
    logic       pat_vld = 1'b0;
    logic [7:0] led;
    logic       glow;

    knight_fade #(.PWM_BITS(PB), .DECAY_DIV(DD)) dut (
        .ck      (ck),
        .res     (res),
        .pat     (pat),
        .pat_vld (pat_vld),
        .led     (led),
        .glow    (glow)
    );

    always #5 ck = ~ck;

    int checks   = 0;
    int failures = 0;

    // reference: levels as integers, time as edges since reset release
    int         mk;
    int         mlvl [8];
    logic [7:0] mled;

    typedef struct {
        logic [7:0] p;
        logic       v;
        logic [7:0] eled;
        logic       eglow;
    } vec_t;

    vec_t tbl [8];
    int   duty [9];
    int   dcnt [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mk   = 0;
        mled = 8'h00;
        for (int i = 0; i < 8; i++) mlvl[i] = 0;
    endtask

    function automatic logic model_glow();
        int any = 0;
        for (int i = 0; i < 8; i++) if (mlvl[i] > 0) any = 1;
        return (any != 0);
    endfunction

    task automatic model_edge(input logic [7:0] p, input logic v);
        bit decay_now;
        decay_now = ((mk % PER) == PER - 1);
        for (int i = 0; i < 8; i++) mled[i] = ((mk % FR) < mlvl[i]);
        for (int i = 0; i < 8; i++) begin
            if (v && p[i]) mlvl[i] = MAXV;
            else if (decay_now && mlvl[i] > 0) mlvl[i] = mlvl[i] - 1;
        end
        mk++;
    endtask

    // one clock: drive at negedge, model at posedge, compare at next negedge
    task automatic cyc(input logic [7:0] p, input logic v);
        pat     = p;
        pat_vld = v;
        @(posedge ck);
        model_edge(p, v);
        @(negedge ck);
        chk($sformatf("led@k%0d", mk - 1), {24'd0, led}, {24'd0, mled});
        chk($sformatf("glow@k%0d", mk - 1), {31'd0, glow}, {31'd0, model_glow()});
    endtask

    task automatic do_reset();
        res     = 1'b0;
        pat     = 8'h00;
        pat_vld = 1'b0;
        model_reset();
        repeat (2) @(posedge ck);
        @(negedge ck);
        res = 1'b1;
    endtask

    initial begin
        tbl[0] = '{8'h01, 1'b1, 8'h00, 1'b1};
        for (int i = 1; i < 7; i++) tbl[i] = '{8'h00, 1'b0, 8'h01, 1'b1};
        tbl[7] = '{8'h00, 1'b0, 8'h00, 1'b1};

        model_reset();

        // reset holds everything low even with requests present
        pat     = 8'hFF;
        pat_vld = 1'b1;
        repeat (3) begin
            @(posedge ck);
            #1;
            chk("rst_led", {24'd0, led}, 32'd0);
            chk("rst_glow", {31'd0, glow}, 32'd0);
        end
        @(negedge ck);
        pat     = 8'h00;
        pat_vld = 1'b0;
        res     = 1'b1;
        repeat (10) cyc(8'h00, 1'b0);
        chk("idle_led", {24'd0, led}, 32'd0);

        // single load, first frame from hand-computed table
        do_reset();
        for (int n = 0; n < 8; n++) begin
            cyc(tbl[n].p, tbl[n].v);
            chk($sformatf("tbl%0d_led", n), {24'd0, led}, {24'd0, tbl[n].eled});
            chk($sformatf("tbl%0d_glow", n), {31'd0, glow}, {31'd0, tbl[n].eglow});
        end

        // decay ladder: per-period duty of led[0] over edges 8..15 of each period
        for (int j = 0; j < 9; j++) duty[j] = 0;
        while (mk < PER * 9) begin
            int e;
            cyc(8'h00, 1'b0);
            e = mk - 1;
            if ((e % PER) >= 8 && (e % PER) <= 15) duty[e / PER] += int'(led[0]);
            if (e == PER * 7 - 2) chk("glow_before_last", {31'd0, glow}, 32'd1);
            if (e == PER * 7 - 1) chk("glow_after_last", {31'd0, glow}, 32'd0);
        end
        for (int j = 0; j < 9; j++)
            chk($sformatf("ladder_duty%0d", j), duty[j], (MAXV - j > 0) ? MAXV - j : 0);

        // load beats decay on a dstep edge; another LED still decays there
        do_reset();
        cyc(8'h04, 1'b1);
        while (mk < 100) cyc(8'h00, 1'b0);
        cyc(8'h08, 1'b1);
        while (mk < PER * 6 - 1) cyc(8'h00, 1'b0);
        cyc(8'h08, 1'b1);
        for (int i = 0; i < 8; i++) dcnt[i] = 0;
        repeat (FR) begin
            cyc(8'h00, 1'b0);
            for (int i = 0; i < 8; i++) dcnt[i] += int'(led[i]);
        end
        chk("prio_led3_duty", dcnt[3], MAXV);
        chk("prio_led2_duty", dcnt[2], 1);

        // sweep trail: one-hot moves every period, trail descends behind it
        do_reset();
        repeat (8) cyc(8'h00, 1'b0);
        for (int s = 0; s < 8; s++) repeat (PER) cyc(8'h01 << s, 1'b1);
        repeat (8) cyc(8'h80, 1'b1);
        for (int i = 0; i < 8; i++) dcnt[i] = 0;
        repeat (FR) begin
            cyc(8'h80, 1'b1);
            for (int i = 0; i < 8; i++) dcnt[i] += int'(led[i]);
        end
        for (int i = 0; i < 8; i++) chk($sformatf("trail_duty%0d", i), dcnt[i], i);

        // async reset between edges with LEDs lit
        chk("pre_async_glow", {31'd0, glow}, 32'd1);
        #2;
        res = 1'b0;
        #1;
        chk("async_led", {24'd0, led}, 32'd0);
        chk("async_glow", {31'd0, glow}, 32'd0);
        model_reset();
        repeat (2) @(posedge ck);
        @(negedge ck);
        res = 1'b1;
        repeat (20) cyc(8'h00, 1'b0);
        chk("post_async_glow", {31'd0, glow}, 32'd0);
        repeat (12) cyc(8'h02, 1'b0);
        cyc(8'h02, 1'b1);
        repeat (40) cyc(8'h00, 1'b0);

        // randomized traffic against the reference
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] p;
            logic       v;
            p = ($urandom_range(0, 1) == 0) ? (8'h01 << $urandom_range(0, 7))
                                            : 8'($urandom_range(0, 255));
            v = ($urandom_range(0, 7) == 0);
            cyc(p, v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/knight_fade.md
# knight_fade

Downstream output stage for the knight LED sequencer. Takes the 8-bit one-hot/sweep pattern the sequencer produces and drives the 8 LEDs with a PWM afterglow. A lit LED snaps to full brightness, then decays one brightness level per decay period, leaving a fading trail behind the moving light.

## Interface
- PWM_BITS, 3, width of PWM counter and per-LED level; MAX = 2^PWM_BITS-1 (default 7)
- DECAY_DIV, 4, PWM frames per decay step; must be ≥1
- ck  in  1  system clock, all state on rising edge
- res  in  1  reset, asynchronous, active-low (res=0 clears all state immediately)
- pat  in  8  pattern from sequencer, bit i = LED i requested on
- pat_vld  in  1  sample strobe for pat; may be held high continuously
- led  out  8  PWM-modulated LED drive, registered
- glow  out  1  high when any LED level is nonzero (combinational OR of level registers)

## Operation
- pcnt: PWM_BITS-bit free-running counter, +1 every cycle, wraps MAX -> 0.
- fend: frame end, true when pcnt == MAX.
- fcnt: counts frames 0..DECAY_DIV-1, advances on fend, wraps to 0 after DECAY_DIV-1.
- dstep: true when fend && fcnt == DECAY_DIV-1 (one cycle per DECAY_DIV*2^PWM_BITS cycles; 32 with defaults).
- lvl[i], i=0..7, PWM_BITS wide, updated each edge with this priority:
  - pat_vld && pat[i] -> lvl[i] = MAX
  - else dstep && lvl[i] != 0 -> lvl[i] - 1
  - else hold; saturates at 0, never wraps
- pat_vld with pat[i]=0 does not clear or alter lvl[i]; it only decays.
- led[i] next = (pcnt < lvl[i]), using current register values; duty = lvl/2^PWM_BITS, so lvl=MAX gives MAX of 2^PWM_BITS cycles on, and lvl=0 gives always off.
- glow = OR over i of (lvl[i] != 0).
- No handshake back to the sequencer; every pat_vld cycle is accepted.

## Timing
- Reset (res=0, async): pcnt=0, fcnt=0, all lvl=0, led=8'h00, glow=0; inputs ignored while res=0.
- First edge after res rises: pcnt 0->1; led computed from pcnt=0.
- Load latency: pat_vld sampled at edge n sets lvl at edge n, so glow is high right after edge n. led reflects the new level at edge n+1.
- Decay: first decrement after a load occurs at the next dstep, 1..32 cycles later depending on phase. Subsequent decrements follow every 32 cycles (defaults). A level-7 LED with no reload reaches 0 after 7 dsteps, i.e. 193..224 cycles.
- Load and dstep on the same edge: load wins (lvl = MAX).
- Reset asserted mid-frame: led drops to 0 without waiting for a clock edge. Counters restart at 0 after release.

## Test plan
- Reset: hold res=0 for 3 edges with pat=8'hFF and pat_vld=1 -> led=8'h00 and glow=0 throughout. After release, with pat_vld=0, led stays 8'h00.
- Single load: one-cycle pat_vld with pat=8'h01 -> glow=1 next cycle. Over the following full frame, led[0] is high 7 of 8 cycles and led[7:1] stays 0.
- Decay ladder: after the load above, no further pat_vld -> led[0] duty steps 7,6,5,...,1,0 (of 8) at each dstep, every 32 cycles. glow falls on the edge of the 7th dstep. The count never wraps back to 7.
- Priority: at lvl[3]=5, pulse pat_vld with pat=8'h08 exactly on a dstep edge -> lvl[3]=7 (duty 7/8), not 4. In the same cycle, another LED at lvl=2 decays to 1.
- Sweep trail: drive one-hot pat shifting left one position every 32 cycles, pat_vld held high -> current LED duty 7/8, previous LEDs 6/8, 5/8, ... descending behind it. Bits not in pat are not cleared by pat_vld.
- Async reset mid-operation: with several LEDs lit, drop res between clock edges -> led=8'h00 and glow=0 before the next edge. After release, pcnt restarts at 0 and all levels stay 0 until a new load.
